// File: rtl/bram_fifo_pkg.sv
// rtl/bram_fifo_pkg.sv - shared types and helpers for the BRAM FIFO controller
package bram_fifo_pkg;

  // Output-buffer occupancy; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    OB_EMPTY = 2'd0,
    OB_ONE   = 2'd1,
    OB_TWO   = 2'd2
  } ob_state_e;

  // Total occupancy reaches DEPTH + 2, so the counter must represent that value.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 3);
  endfunction

endpackage

// File: rtl/bram_fifo_obuf.sv
// rtl/bram_fifo_obuf.sv - two-entry output buffer that absorbs the RAM read latency
module bram_fifo_obuf
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 96
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  land_valid,
  input  logic [DATA_WIDTH-1:0] land_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            ob_cnt
);

  ob_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  pop;

  assign m_valid = (state_q != OB_EMPTY);
  assign m_data  = head_q;
  assign ob_cnt  = state_q;
  assign pop     = m_valid && m_ready;

  // Next buffer contents: head is always the oldest word, so it only changes on a pop or first landing.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      OB_EMPTY: begin
        if (land_valid) begin
          head_d  = land_data;
          state_d = OB_ONE;
        end
      end
      OB_ONE: begin
        case ({land_valid, pop})
          2'b10: begin
            tail_d  = land_data;
            state_d = OB_TWO;
          end
          2'b01:   state_d = OB_EMPTY;
          2'b11:   head_d  = land_data;
          default: state_d = OB_ONE;
        endcase
      end
      OB_TWO: begin
        if (pop) begin
          head_d = tail_q;
          if (land_valid) begin
            tail_d = land_data;
          end else begin
            state_d = OB_ONE;
          end
        end
      end
      default: state_d = OB_EMPTY;
    endcase
  end

  // Buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OB_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// rtl/bram_fifo_ctrl.sv - first-word-fall-through FIFO controller for an external dual-port RAM
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 96,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  bram_en_a,
  output logic                  bram_we_a,
  output logic [ADDR_WIDTH-1:0] bram_addr_a,
  output logic [DATA_WIDTH-1:0] bram_din_a,
  output logic                  bram_en_b,
  output logic [ADDR_WIDTH-1:0] bram_addr_b,
  input  logic [DATA_WIDTH-1:0] bram_dout_b
);

  localparam logic [CNT_WIDTH-1:0]  MEM_FULL  = CNT_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  mem_cnt_q, mem_cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  push, pop, rd;
  logic [1:0]            ob_cnt;
  logic [2:0]            ob_pending;

  // s_ready depends only on registered state, never on m_ready.
  assign s_ready    = rst_n && (mem_cnt_q < MEM_FULL);
  assign push       = s_valid && s_ready;
  assign pop        = m_valid && m_ready;
  // Words already committed to the buffer: held entries plus the read landing this cycle.
  assign ob_pending = {1'b0, ob_cnt} + {2'b00, inflight_q};
  // A read lands next cycle, so issue only if the buffer will have room after this cycle's pop.
  assign rd         = rst_n && (mem_cnt_q != '0) && (ob_pending < (3'd2 + {2'b00, pop}));

  assign bram_en_a   = push;
  assign bram_we_a   = push;
  assign bram_addr_a = wr_ptr_q;
  assign bram_din_a  = s_data;
  assign bram_en_b   = rd;
  assign bram_addr_b = rd_ptr_q;
  assign count       = mem_cnt_q + CNT_WIDTH'(inflight_q) + CNT_WIDTH'(ob_cnt);

  // Pointer, RAM occupancy and in-flight read bookkeeping; pointers wrap explicitly for any DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == ADDR_LAST) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (rd) begin
      rd_ptr_d = (rd_ptr_q == ADDR_LAST) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
    end
    mem_cnt_d  = mem_cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(rd);
    inflight_d = rd;
  end

  // Controller state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  bram_fifo_obuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .land_valid(inflight_q),
    .land_data (bram_dout_b),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .ob_cnt    (ob_cnt)
  );

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb/tb_bram_fifo_ctrl.sv - self-checking bench for bram_fifo_ctrl at DEPTH 8 and DEPTH 5
module tb_bram_fifo_ctrl;

  logic        clk;
  logic        rst_n, s_valid, m_ready;
  logic [15:0] s_data;

  logic        s_ready8, m_valid8, en_a8, we_a8, en_b8;
  logic [15:0] m_data8, din_a8, dout8;
  logic [2:0]  addr_a8, addr_b8;
  logic [3:0]  count8;
  logic        s_ready5, m_valid5, en_a5, we_a5, en_b5;
  logic [15:0] m_data5, din_a5, dout5;
  logic [2:0]  addr_a5, addr_b5;
  logic [2:0]  count5;

  logic [15:0] ram8 [0:7];
  logic [15:0] ram5 [0:4];

  logic [1:0]       s_ready_w, m_valid_w, en_a_w, we_a_w, en_b_w;
  logic [1:0][15:0] m_data_w, din_a_w;
  logic [1:0][2:0]  addr_a_w, addr_b_w;
  logic [1:0][3:0]  cnt_w;

  assign s_ready_w = {s_ready5, s_ready8};
  assign m_valid_w = {m_valid5, m_valid8};
  assign en_a_w    = {en_a5, en_a8};
  assign we_a_w    = {we_a5, we_a8};
  assign en_b_w    = {en_b5, en_b8};
  assign m_data_w  = {m_data5, m_data8};
  assign din_a_w   = {din_a5, din_a8};
  assign addr_a_w  = {addr_a5, addr_a8};
  assign addr_b_w  = {addr_b5, addr_b8};
  assign cnt_w     = {{1'b0, count5}, count8};

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bram_fifo_ctrl #(.DATA_WIDTH(16), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready8), .s_data(s_data),
    .m_valid(m_valid8), .m_ready(m_ready), .m_data(m_data8), .count(count8),
    .bram_en_a(en_a8), .bram_we_a(we_a8), .bram_addr_a(addr_a8), .bram_din_a(din_a8),
    .bram_en_b(en_b8), .bram_addr_b(addr_b8), .bram_dout_b(dout8)
  );

  bram_fifo_ctrl #(.DATA_WIDTH(16), .DEPTH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready5), .s_data(s_data),
    .m_valid(m_valid5), .m_ready(m_ready), .m_data(m_data5), .count(count5),
    .bram_en_a(en_a5), .bram_we_a(we_a5), .bram_addr_a(addr_a5), .bram_din_a(din_a5),
    .bram_en_b(en_b5), .bram_addr_b(addr_b5), .bram_dout_b(dout5)
  );

  // Simple dual-port RAMs with registered read data that holds while port B is idle.
  always @(posedge clk) begin
    if (en_a8 && we_a8) ram8[addr_a8] <= din_a8;
    if (en_b8) dout8 <= ram8[addr_b8];
    if (en_a5 && we_a5 && addr_a5 < 3'd5) ram5[addr_a5] <= din_a5;
    if (en_b5) dout5 <= (addr_b5 < 3'd5) ? ram5[addr_b5] : 16'hxxxx;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: an ordered list of accepted-but-unpopped words plus a count of
  // words written to RAM and not yet read, with address sequences modulo DEPTH.
  int          dep [2] = '{8, 5};
  int          mem_m [2];
  int          wrp [2];
  int          rdp [2];
  int          head [2];
  int          tail [2];
  logic [15:0] sb [2][32];
  int          outst;
  logic        push_m, pop_m;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk($sformatf("d%0d_s_ready_in_reset", dep[i]), {31'b0, s_ready_w[i]}, 32'd0);
        mem_m[i] = 0; wrp[i] = 0; rdp[i] = 0; head[i] = 0; tail[i] = 0;
      end else begin
        push_m = s_valid && s_ready_w[i];
        pop_m  = m_valid_w[i] && m_ready;
        outst  = tail[i] - head[i];
        chk($sformatf("d%0d_s_ready", dep[i]), {31'b0, s_ready_w[i]}, {31'b0, mem_m[i] < dep[i]});
        chk($sformatf("d%0d_count", dep[i]), {28'b0, cnt_w[i]}, outst);
        if (m_valid_w[i]) begin
          chk($sformatf("d%0d_valid_nonempty", dep[i]), {31'b0, outst > 0}, 32'd1);
          if (outst > 0)
            chk($sformatf("d%0d_m_data", dep[i]), {16'b0, m_data_w[i]}, {16'b0, sb[i][head[i] % 32]});
        end
        chk($sformatf("d%0d_en_a", dep[i]), {31'b0, en_a_w[i]}, {31'b0, push_m});
        chk($sformatf("d%0d_we_a", dep[i]), {31'b0, we_a_w[i]}, {31'b0, en_a_w[i]});
        if (push_m) begin
          chk($sformatf("d%0d_addr_a", dep[i]), {29'b0, addr_a_w[i]}, wrp[i]);
          chk($sformatf("d%0d_din_a", dep[i]), {16'b0, din_a_w[i]}, {16'b0, s_data});
          sb[i][tail[i] % 32] = s_data;
          tail[i]++;
          wrp[i] = (wrp[i] + 1) % dep[i];
        end
        if (en_b_w[i]) begin
          chk($sformatf("d%0d_read_nonempty", dep[i]), {31'b0, mem_m[i] > 0}, 32'd1);
          chk($sformatf("d%0d_addr_b", dep[i]), {29'b0, addr_b_w[i]}, rdp[i]);
          rdp[i] = (rdp[i] + 1) % dep[i];
          mem_m[i]--;
        end
        if (push_m) mem_m[i]++;
        if (pop_m) head[i]++;
      end
    end
  end

  typedef struct {
    logic        sv;
    logic [15:0] sd;
    logic        mr;
    logic        e_sr;
    logic        e_mv;
    logic [15:0] e_md;
    logic [3:0]  e_cnt;
    logic        e_enb;
  } vec_t;

  vec_t tbl [6];

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  int acc0, acc1, nxt, first, gaps, out0, out1, sent, last_acc, pops1, maxc0, maxc1;

  initial begin
    // {s_valid, s_data, m_ready, exp s_ready, exp m_valid, exp m_data, exp count, exp en_b}
    tbl[0] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0};
    tbl[1] = '{1'b1, 16'h00a5, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0};
    tbl[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd1, 1'b1};
    tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd1, 1'b0};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h00a5, 4'd1, 1'b0};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0};

    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      s_valid = tbl[v].sv; s_data = tbl[v].sd; m_ready = tbl[v].mr;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("vec%0d_d%0d_s_ready", v, dep[i]), {31'b0, s_ready_w[i]}, {31'b0, tbl[v].e_sr});
        chk($sformatf("vec%0d_d%0d_m_valid", v, dep[i]), {31'b0, m_valid_w[i]}, {31'b0, tbl[v].e_mv});
        chk($sformatf("vec%0d_d%0d_count", v, dep[i]), {28'b0, cnt_w[i]}, {28'b0, tbl[v].e_cnt});
        chk($sformatf("vec%0d_d%0d_en_b", v, dep[i]), {31'b0, en_b_w[i]}, {31'b0, tbl[v].e_enb});
        if (tbl[v].e_mv)
          chk($sformatf("vec%0d_d%0d_m_data", v, dep[i]), {16'b0, m_data_w[i]}, {16'b0, tbl[v].e_md});
      end
      next_cyc();
    end

    // Fill with the consumer stalled: DEPTH + 2 words fit.
    acc0 = 0; acc1 = 0; nxt = 0; m_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      s_valid = (nxt < 12); s_data = nxt[15:0];
      @(negedge clk);
      if (s_valid && s_ready8) begin acc0++; nxt++; end
      if (s_valid && s_ready5) acc1++;
      next_cyc();
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("fill_acc_d8", acc0, 32'd10);
    chk("fill_acc_d5", acc1, 32'd7);
    chk("fill_count_d8", {28'b0, count8}, 32'd10);
    chk("fill_count_d5", {29'b0, count5}, 32'd7);
    chk("fill_s_ready_d8", {31'b0, s_ready8}, 32'd0);
    next_cyc();

    // Drain back-to-back: one word per cycle in order.
    m_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_valid_d8", k), {31'b0, m_valid8}, {31'b0, k < 10});
      if (k < 10) chk($sformatf("drain%0d_data_d8", k), {16'b0, m_data8}, k);
      chk($sformatf("drain%0d_valid_d5", k), {31'b0, m_valid5}, {31'b0, k < 7});
      if (k < 7) chk($sformatf("drain%0d_data_d5", k), {16'b0, m_data5}, k);
      next_cyc();
    end

    // Streaming 1000 words with the consumer always ready.
    first = -1; gaps = 0; out0 = 0; out1 = 0; sent = 0; last_acc = -1;
    for (int c = 0; c < 1020; c++) begin
      s_valid = (sent < 1000); s_data = sent[15:0];
      @(negedge clk);
      if (s_valid && s_ready8) begin sent++; last_acc = c; end
      if (m_valid5) out1++;
      if (m_valid8) begin
        if (first < 0) first = c;
        out0++;
      end else if (first >= 0 && out0 < 1000) begin
        gaps++;
      end
      next_cyc();
    end
    chk("stream_latency", first, 32'd3);
    chk("stream_gaps", gaps, 32'd0);
    chk("stream_out_d8", out0, 32'd1000);
    chk("stream_out_d5", out1, 32'd1000);
    chk("stream_last_accept", last_acc, 32'd999);

    // Random traffic with 50% valid and 50% ready.
    pops1 = 0; maxc0 = 0; maxc1 = 0;
    for (int c = 0; c < 60000 && pops1 < 10000; c++) begin
      s_valid = 1'($urandom_range(0, 1)); s_data = 16'($urandom); m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (m_valid5 && m_ready) pops1++;
      if (int'(count8) > maxc0) maxc0 = int'(count8);
      if (int'(count5) > maxc1) maxc1 = int'(count5);
      next_cyc();
    end
    chk("rand_words_done", {31'b0, pops1 >= 10000}, 32'd1);
    chk("rand_max_count_d5_le7", {31'b0, maxc1 <= 7}, 32'd1);
    chk("rand_max_count_d8_le10", {31'b0, maxc0 <= 10}, 32'd1);
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (20) next_cyc();
    @(negedge clk);
    chk("rand_drained_d8", {28'b0, count8}, 32'd0);
    chk("rand_drained_d5", {29'b0, count5}, 32'd0);
    next_cyc();

    // Reset in the middle of traffic, then a fresh word.
    m_ready = 1'b0; s_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_data = 16'h0100 + 16'(k);
      next_cyc();
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_count_d8", {28'b0, count8}, 32'd4);
    chk("pre_reset_count_d5", {29'b0, count5}, 32'd4);
    next_cyc();
    rst_n = 1'b0;
    next_cyc();
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("post_reset_d%0d_m_valid", dep[i]), {31'b0, m_valid_w[i]}, 32'd0);
      chk($sformatf("post_reset_d%0d_count", dep[i]), {28'b0, cnt_w[i]}, 32'd0);
      chk($sformatf("post_reset_d%0d_s_ready", dep[i]), {31'b0, s_ready_w[i]}, 32'd1);
    end
    next_cyc();
    s_valid = 1'b1; s_data = 16'h003c;
    @(negedge clk);
    next_cyc();
    s_valid = 1'b0;
    for (int d = 1; d <= 3; d++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("reset_word_t%0d_d%0d_valid", d, dep[i]), {31'b0, m_valid_w[i]}, {31'b0, d == 3});
        if (d == 3) chk($sformatf("reset_word_d%0d_data", dep[i]), {16'b0, m_data_w[i]}, 32'h3c);
      end
      next_cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_fifo_ctrl.md
# bram_fifo_ctrl

First-word-fall-through FIFO controller that sequences an external simple dual-port block RAM. The RAM has a write port A, a read port B, and a registered read output that holds its value while read-enable is low. The block owns the write/read pointers and occupancy. It hides the RAM's one-cycle read latency behind a two-entry output buffer, so the consumer sees a plain valid/ready stream. It sits between a streaming producer (e.g. a command/data ingress path) and its consumer, one instance per RAM.

## Interface
- DATA_WIDTH, 96, payload width; equals RAM data width
- DEPTH, 256, RAM entries; any value ≥ 2, not restricted to powers of two
- ADDR_WIDTH, $clog2(DEPTH), RAM address width
- CNT_WIDTH, $clog2(DEPTH+3), occupancy counter width
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- s_valid  in  1  producer data valid
- s_ready  out  1  controller can accept
- s_data  in  DATA_WIDTH  producer payload
- m_valid  out  1  head-of-FIFO valid
- m_ready  in  1  consumer accepts head
- m_data  out  DATA_WIDTH  head-of-FIFO payload
- count  out  CNT_WIDTH  total occupancy, counting RAM, in-flight read and output buffer
- bram_en_a, bram_we_a  out  1  RAM port-A enable and write strobe; both driven identically
- bram_addr_a  out  ADDR_WIDTH  RAM write address
- bram_din_a  out  DATA_WIDTH  RAM write data; equals s_data
- bram_en_b  out  1  RAM port-B read enable
- bram_addr_b  out  ADDR_WIDTH  RAM read address
- bram_dout_b  in  DATA_WIDTH  RAM registered read data

## Operation
- Push: push = s_valid && s_ready. It drives bram_en_a = bram_we_a = 1 with bram_addr_a = wr_ptr, then advances wr_ptr.
- s_ready = rst_n && (mem_cnt < DEPTH), where mem_cnt counts entries written to RAM but not yet read. No combinational path from m_ready.
- Read issue: rd = (mem_cnt > 0) && (ob_cnt + inflight − pop < 2). It drives bram_en_b = 1 with bram_addr_b = rd_ptr, advances rd_ptr, and sets inflight for the next cycle.
- Landing: when inflight = 1, bram_dout_b is captured into the output buffer at the next edge.
- Output buffer: two entries with states EMPTY/ONE/TWO (ob_cnt 0/1/2). m_valid = (ob_cnt ≠ 0). m_data = head entry.
- Pop: pop = m_valid && m_ready.
  - A pop and a landing in the same cycle keep ob_cnt unchanged.
  - Never land while ob_cnt = 2 without a pop; the read-issue rule guarantees this.
- Pointers wrap from DEPTH−1 to 0 explicitly.
- Counter updates:
  - mem_cnt += push − rd.
  - count = mem_cnt + inflight + ob_cnt, maximum DEPTH+2.
- Simultaneous push and read with mem_cnt = 0: no read is issued that cycle. A read never targets an address written in the same cycle, so the RAM's read-during-write behaviour is irrelevant.
- Simultaneous push and pop at full (mem_cnt = DEPTH): s_ready is 0, so the push is refused. The pop frees output space and lets a read issue, which frees RAM space next cycle.

## Timing
- Reset (rst_n = 0 at an edge):
  - wr_ptr, rd_ptr, mem_cnt, inflight, ob_cnt all go to 0. m_valid = 0, count = 0, bram_en_a/we_a/en_b = 0.
  - s_ready = 0 while rst_n is low.
  - Reset mid-operation discards all contents; RAM contents are not cleared and not used.
- Write into an empty FIFO accepted in cycle T:
  - T+1: RAM read issued.
  - T+2: bram_dout_b valid.
  - T+3: m_valid = 1.
  - Latency is 3 cycles.
- Steady state with continuous m_ready = 1 and a non-empty RAM: one word per cycle, no bubbles.
- s_ready falls in the cycle after the DEPTH-th unread RAM write. count reaches DEPTH+2 only once both output-buffer entries are full.
- m_data is stable while m_valid && !m_ready.

## Structure
- Shared package bram_fifo_pkg holds:
  - the output-buffer state enum (OB_EMPTY, OB_ONE, OB_TWO);
  - a width helper function for CNT_WIDTH.
- One natural sub-module: bram_fifo_obuf, the two-entry output buffer with its valid/ready and landing input.
- The RAM stays external. The controller contains pointers, counters and read-issue logic only.

## Test plan
- Single word: reset, push 0xA5 at T with m_ready = 0 → m_valid rises at T+3 with m_data = 0xA5, count = 1; pop → m_valid = 0 and count = 0 next cycle.
- Fill: DEPTH = 8, m_ready = 0, push 0..11 → s_ready drops after exactly 10 accepted words (8 RAM + 2 buffer), count = 10.
  - Then m_ready = 1: out 0..9 in order, one per cycle after the first.
- Streaming: continuous push and pop of 1000 incrementing words with DEPTH = 8 → output equals input, no gaps after the initial 3-cycle latency, pointers wrap with no loss.
- Random backpressure: random s_valid and m_ready (50%) over 10 000 words, DEPTH = 5 (non-power-of-two) → scoreboard matches; bram_en_b never asserted with mem_cnt = 0; count never exceeds 7.
- Reset mid-stream: assert rst_n = 0 for 1 cycle while count = 4 → next cycle m_valid = 0, count = 0, s_ready = 1. A new word 0x3C then emerges with 3-cycle latency and no stale data.
